// File: rtl/bcd_counter_pkg.sv
// bcd_pkg: shared digit type, BCD limits and nibble helpers for bcd_counter.
// Optional feature macro used across the slice: BCD_COUNTER_DOWN_EN (adds dn).
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX) ? 1'b1 : 1'b0;
  endfunction

  // Illegal nibbles collapse to zero so the register only ever holds BCD.
  function automatic bcd_digit_t sanitize(input bcd_digit_t nibble);
    return is_bcd(nibble) ? nibble : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// bcd_counter_if: control/data bundle between a driver and bcd_counter.
// With BCD_COUNTER_DOWN_EN defined the bundle also carries the dn select.
interface bcd_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
`ifdef BCD_COUNTER_DOWN_EN
  logic                  dn;
`endif
  logic [4*DIGITS-1:0]   count;
  logic                  carry_out;
  logic                  load_err;

  modport master (
    output en,
    output load,
    output load_val,
`ifdef BCD_COUNTER_DOWN_EN
    output dn,
`endif
    input  count,
    input  carry_out,
    input  load_err
  );

  modport slave (
    input  en,
    input  load,
    input  load_val,
`ifdef BCD_COUNTER_DOWN_EN
    input  dn,
`endif
    output count,
    output carry_out,
    output load_err
  );

endinterface

// File: rtl/bcd_counter_digit.sv
// bcd_digit: one decimal digit register with increment (and optional
// decrement under BCD_COUNTER_DOWN_EN) plus its combinational carry/borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load,
  input  bcd_digit_t load_nibble,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       dn,
`endif
  output bcd_digit_t q,
  output logic       carry
);

  bcd_digit_t q_r;
  bcd_digit_t q_next_s;
  logic       carry_s;

  // Next digit value: load beats step; anything out of range wraps safely.
  always_comb begin
    q_next_s = q_r;
    if (load) begin
      q_next_s = load_nibble;
    end else if (step) begin
`ifdef BCD_COUNTER_DOWN_EN
      if (dn) begin
        q_next_s = ((q_r == BCD_MIN) || !is_bcd(q_r)) ? BCD_MAX : (q_r - 4'd1);
      end else begin
        q_next_s = (q_r >= BCD_MAX) ? BCD_MIN : (q_r + 4'd1);
      end
`else
      q_next_s = (q_r >= BCD_MAX) ? BCD_MIN : (q_r + 4'd1);
`endif
    end else begin
      q_next_s = q_r;
    end
  end

  // Carry (or borrow) into the next digit when this one is at its limit.
  always_comb begin
    carry_s = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
    if (dn) begin
      carry_s = step & (q_r == BCD_MIN);
    end else begin
      carry_s = step & (q_r == BCD_MAX);
    end
`else
    carry_s = step & (q_r == BCD_MAX);
`endif
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= BCD_MIN;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q     = q_r;
  assign carry = carry_s;

endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: DIGITS-wide synchronous BCD counter with parallel load,
// load sanitising, wrap pulse and load error flag. The ripple carry is
// purely combinational across all digits. Define BCD_COUNTER_DOWN_EN to
// add the dn (count down) input on the interface.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bcd_counter_if.slave   bus
);

  logic [DIGITS-1:0]   step_s;
  logic [DIGITS-1:0]   carry_s;
  logic [DIGITS-1:0]   bad_nibble_s;
  bcd_digit_t          load_nibble_s [DIGITS];
  bcd_digit_t          digit_q_s     [DIGITS];
  logic [4*DIGITS-1:0] count_s;
  logic                carry_out_r;
  logic                load_err_r;

  // Ripple chain: digit 0 steps on en, each higher digit on the carry below.
  always_comb begin
    step_s    = '0;
    step_s[0] = bus.en;
    for (int i = 1; i < DIGITS; i++) begin
      step_s[i] = carry_s[i-1];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign load_nibble_s[i]  = sanitize(bus.load_val[4*i +: 4]);
    assign bad_nibble_s[i]   = ~is_bcd(bus.load_val[4*i +: 4]);
    assign count_s[4*i +: 4] = digit_q_s[i];

    bcd_digit u_digit (
      .clk         (clk),
      .rst         (rst),
      .step        (step_s[i]),
      .load        (bus.load),
      .load_nibble (load_nibble_s[i]),
`ifdef BCD_COUNTER_DOWN_EN
      .dn          (bus.dn),
`endif
      .q           (digit_q_s[i]),
      .carry       (carry_s[i])
    );
  end

  // Status flags: wrap pulse is suppressed by a load; error only on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_out_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      carry_out_r <= (~bus.load) & carry_s[DIGITS-1];
      load_err_r  <= bus.load & (|bad_nibble_s);
    end
  end

  assign bus.count     = count_s;
  assign bus.carry_out = carry_out_r;
  assign bus.load_err  = load_err_r;

endmodule
